// File: rtl/alu_ctrl.sv
// alu_ctrl: request/response sequencer for the 16-bit ALU, owning the C/Z/V/S flag register.
// Optional saturating add (op 11) is built when ALU_CTRL_SAT_EN is defined.
module alu_ctrl #(
  parameter logic [2:0]  IDLE_FUNC = 3'b111,
  parameter logic [15:0] ERR_DATA  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [3:0]  req_cnt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        flag_c,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_s,
  input  logic        flag_we,
  input  logic [3:0]  flag_wdata,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_func,
  output logic        alu_cin,
  input  logic [15:0] alu_out,
  input  logic        alu_c,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        alu_s
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;
  localparam logic [3:0] OP_TST = 4'd10;
`ifdef ALU_CTRL_SAT_EN
  localparam logic [3:0] OP_ADDS = 4'd11;
`endif

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_SUB = 3'b001;
  localparam logic [2:0] F_AND = 3'b010;
  localparam logic [2:0] F_OR  = 3'b011;
  localparam logic [2:0] F_XOR = 3'b100;
  localparam logic [2:0] F_SHL = 3'b101;
  localparam logic [2:0] F_SHR = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // ALU port registers double as the operand registers; r_alu_b is the shift accumulator
  logic [15:0] r_alu_a;
  logic [15:0] r_alu_b;
  logic [2:0]  r_alu_func;
  logic        r_alu_cin;
  logic [3:0]  r_op;
  logic [3:0]  r_cnt;

  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_data;
  logic        r_rsp_err;
  logic        r_flag_c;
  logic        r_flag_z;
  logic        r_flag_v;
  logic        r_flag_s;

  logic        w_legal;
  logic        w_shift;
  logic [2:0]  w_func;
  logic        w_cin;
  logic [15:0] w_a;
  logic [3:0]  w_cnt_init;
  logic        w_capture;
  logic [15:0] w_res;
  logic        w_fc;
  logic        w_fz;
  logic        w_fv;
  logic        w_fs;
`ifdef ALU_CTRL_SAT_EN
  logic [15:0] w_sat;
`endif

  assign w_capture = (r_state == S_EXEC) && (r_cnt == 4'd1);

  // Opcode decode of the incoming request into ALU controls
  always_comb begin
    w_legal = 1'b1;
    w_shift = 1'b0;
    w_func  = IDLE_FUNC;
    w_cin   = 1'b0;
    w_a     = req_a;
    case (req_op)
      OP_ADD: w_func = F_ADD;
      OP_ADC: begin
        w_func = F_ADD;
        w_cin  = r_flag_c;
      end
      OP_SUB: w_func = F_SUB;
      OP_SBC: begin
        w_func = F_SUB;
        w_cin  = r_flag_c;
      end
      OP_AND: w_func = F_AND;
      OP_OR:  w_func = F_OR;
      OP_XOR: w_func = F_XOR;
      OP_SHL, OP_SHR: begin
        w_shift = 1'b1;
        // A zero-length shift is an OR with zero: result=b, c=0, v=0
        if (req_cnt == 4'd0) begin
          w_func = F_OR;
          w_a    = 16'h0000;
        end else begin
          w_func = (req_op == OP_SHL) ? F_SHL : F_SHR;
        end
      end
      OP_CMP: w_func = F_SUB;
      OP_TST: w_func = F_AND;
`ifdef ALU_CTRL_SAT_EN
      OP_ADDS: w_func = F_ADD;
`endif
      default: w_legal = 1'b0;
    endcase
  end

  assign w_cnt_init = (w_shift && (req_cnt != 4'd0)) ? req_cnt : 4'd1;

`ifdef ALU_CTRL_SAT_EN
  assign w_sat = r_alu_a[15] ? 16'h8000 : 16'h7FFF;
`endif

  // Result and flag values presented at the capture edge
  always_comb begin
    w_res = alu_out;
    w_fc  = alu_c;
    w_fz  = alu_z;
    w_fv  = alu_v;
    w_fs  = alu_s;
    case (r_op)
      OP_AND, OP_OR, OP_XOR: begin
        w_fc = 1'b0;
        w_fv = 1'b0;
      end
      OP_TST: begin
        w_res = r_alu_b;
        w_fc  = 1'b0;
        w_fv  = 1'b0;
      end
      OP_CMP: w_res = r_alu_b;
      OP_SHL, OP_SHR: w_fv = 1'b0;
`ifdef ALU_CTRL_SAT_EN
      OP_ADDS: begin
        if (alu_v) begin
          w_res = w_sat;
          w_fz  = (w_sat == 16'h0000);
          w_fs  = w_sat[15];
        end else begin
          w_res = alu_out;
        end
      end
`endif
      default: w_res = alu_out;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; illegal opcodes bypass EXEC
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_state_nxt = w_legal ? S_EXEC : S_RESP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        if (w_capture) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, shift iteration, result capture and handshake registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a     <= 16'h0000;
      r_alu_b     <= 16'h0000;
      r_alu_func  <= IDLE_FUNC;
      r_alu_cin   <= 1'b0;
      r_op        <= 4'd0;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'h0000;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op        <= req_op;
            r_req_ready <= 1'b0;
            if (w_legal) begin
              r_alu_a    <= w_a;
              r_alu_b    <= req_b;
              r_alu_func <= w_func;
              r_alu_cin  <= w_cin;
              r_cnt      <= w_cnt_init;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= ERR_DATA;
            end
          end
        end
        S_EXEC: begin
          if (w_capture) begin
            r_rsp_data  <= w_res;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_alu_a     <= 16'h0000;
            r_alu_b     <= 16'h0000;
            r_alu_func  <= IDLE_FUNC;
            r_alu_cin   <= 1'b0;
            r_cnt       <= 4'd0;
          end else begin
            r_alu_b <= alu_out;
            r_cnt   <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: r_req_ready <= 1'b1;
      endcase
    end
  end

  // Flag register: capture edge has priority over a software write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_v <= 1'b0;
      r_flag_s <= 1'b0;
    end else if (w_capture) begin
      r_flag_c <= w_fc;
      r_flag_z <= w_fz;
      r_flag_v <= w_fv;
      r_flag_s <= w_fs;
    end else if (flag_we) begin
      r_flag_c <= flag_wdata[3];
      r_flag_z <= flag_wdata[2];
      r_flag_v <= flag_wdata[1];
      r_flag_s <= flag_wdata[0];
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign flag_c    = r_flag_c;
  assign flag_z    = r_flag_z;
  assign flag_v    = r_flag_v;
  assign flag_s    = r_flag_s;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_func  = r_alu_func;
  assign alu_cin   = r_alu_cin;

endmodule

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
- Sequencer in front of the 16-bit combinational ALU (func 000 add, 001 sub b-a-cin, 010 and, 011 or, 100 xor, 101 shl1, 110 shr1).
- Accepts one operation request at a time over a valid/ready handshake and drives the ALU operand, func and cin ports.
- Iterates the ALU for multi-bit shifts, owns the architectural flag register (C,Z,V,S) and returns the result over a valid/ready response channel.

Parameters:
IDLE_FUNC, 3'b111, alu_func driven when no op executing (ALU outputs 0)
ERR_DATA, 16'h0000, rsp_data returned for illegal opcodes

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept (high only in IDLE)
req_op  in  4  opcode (see Behaviour)
req_a  in  16  operand A
req_b  in  16  operand B (minuend for SUB, shift source)
req_cnt  in  4  shift amount 0..15 (shift ops only)
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_data  out  16  result
rsp_err  out  1  illegal opcode flag, valid with rsp_valid
flag_c, flag_z, flag_v, flag_s  out  1 each  flag register
flag_we  in  1  software flag write
flag_wdata  in  4  {c,z,v,s} for flag_we
alu_a, alu_b  out  16  to ALU
alu_func  out  3  to ALU
alu_cin  out  1  to ALU
alu_out  in  16  from ALU
alu_c, alu_z, alu_v, alu_s  in  1 each  from ALU

Behaviour:
- Opcodes. All ALU ops use a=req_a, b=req_b.
  - 0 ADD: func 000, cin 0.
  - 1 ADC: func 000, cin=flag_c.
  - 2 SUB: func 001, cin 0.
  - 3 SBC: func 001, cin=flag_c.
  - 4 AND, 5 OR, 6 XOR.
  - 7 SHL, 8 SHR: iterate func 101/110 on b.
  - 9 CMP: as SUB; rsp_data=req_b; flags updated.
  - 10 TST: as AND; rsp_data=req_b; flags updated.
  - 11-15: illegal.
- cin for ADC/SBC is flag_c as registered before the accept edge; a coincident flag_we does not affect it.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: req_ready=1. req_valid at an edge registers op, a, b, cnt and goes to EXEC. An illegal op goes directly to RESP with rsp_err=1 and rsp_data=ERR_DATA; flags are unchanged.
  - EXEC: ALU ports driven from registered operands.
    - Non-shift ops: 1 cycle. Result and flags are captured at the EXEC edge.
    - Shift with cnt>=1: cnt cycles. Each edge writes alu_out back into the b register and decrements the count. Capture happens on the final edge.
    - Shift with cnt=0: 1 cycle, func 011 with a=0, so result=b, c=0, v=0.
  - RESP: rsp_valid=1. rsp_data and rsp_err are held stable until rsp_ready. At that edge the FSM goes to IDLE; rsp_valid drops at that edge.
- Latency: accept edge E0. rsp_valid is high after edge E0+1 (non-shift) or E0+max(cnt,1) (shift). Illegal ops: rsp_valid is high after E0.
- Back-to-back throughput: a new request is accepted no earlier than the cycle after the response handshake.
- Flags at capture:
  - c, z, v, s come from the ALU outputs of the final EXEC cycle.
  - Shifts: c is the last bit shifted out and v=0.
  - Logic ops: c=0, v=0.
- flag_we loads flag_wdata at any edge that is not a capture edge. A capture edge wins over flag_we.
- Outside EXEC: alu_a=0, alu_b=0, alu_cin=0, alu_func=IDLE_FUNC.
- Reset: state IDLE, all flags 0, rsp_valid=0, rsp_data=0, rsp_err=0, alu_* idle values.
  - Reset during EXEC or RESP aborts the op. No response is issued and flags are not updated.

Optional Feature:
ALU_CTRL_SAT_EN
- Defined: op 11 is ADDS (func 000, cin 0). If alu_v=1, the result is replaced by 16'h8000 when a[15]=1, else 16'h7FFF.
  - v=1; c taken from the ALU.
  - z and s recomputed from the saturated result.
  - Latency as ADD.
- Undefined: op 11 is illegal, like ops 12-15.

Test Plan:
- ADD a=16'h7FFF b=16'h0001 accepted at E0 -> rsp_valid after E0+1, rsp_data=16'h8000, c=0 z=0 v=1 s=1.
- ADD a=16'hFFFF b=16'h0001, then ADC a=0 b=0 -> first returns 16'h0000 with c=1 z=1; ADC returns 16'h0001 (cin=1 seen on alu_cin).
- SHL b=16'h8001 cnt=3 -> alu_func=101 for exactly 3 cycles, rsp_data=16'h0008, c=0. Then SHR b=16'h0003 cnt=1 -> 16'h0001, c=1.
- SUB a=5 b=3 with rsp_ready held low 5 cycles -> rsp_data=16'hFFFE stable all 5 cycles, c=1 s=1, req_ready=0 until handshake.
- SHL cnt=15, rst pulsed on 4th EXEC cycle -> next cycle all outputs at reset values, no rsp_valid, flags 0.
- op=14 -> rsp_valid after E0 with rsp_err=1, rsp_data=ERR_DATA, flags unchanged. With ALU_CTRL_SAT_EN, op=11 a=16'h7000 b=16'h7000 -> rsp_data=16'h7FFF, v=1.
